// File: rtl/branch_history_table.sv
// Fetch-stage direction predictor: a table of 2-bit saturating counters indexed by PC,
// optionally XORed with global branch history (gshare), trained by the execute stage.
module branch_history_table #(
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           pc_i,
  input  logic                  is_branch_i,
  input  logic [31:0]           pc_next_i,
  input  logic [31:0]           pc_plus_4_i,
  output logic                  predict_taken_o,
  output logic [31:0]           pc_predict_o,
  output logic [INDEX_BITS-1:0] predict_idx_o,
  input  logic                  update_en_i,
  input  logic [INDEX_BITS-1:0] update_idx_i,
  input  logic                  update_taken_i,
  input  logic                  update_mispred_i,
  output logic [CNT_WIDTH-1:0]  branch_cnt_o,
  output logic [CNT_WIDTH-1:0]  mispred_cnt_o
);

  localparam int ENTRIES = 2 ** INDEX_BITS;

  logic [1:0]            table_q [ENTRIES];
  logic [INDEX_BITS-1:0] hist_idx;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [1:0]            lookup_cnt;
  logic [1:0]            upd_cnt;
  logic [1:0]            upd_cnt_next;
  logic [CNT_WIDTH-1:0]  branch_cnt_q;
  logic [CNT_WIDTH-1:0]  mispred_cnt_q;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{pc_i[31:INDEX_BITS+2], pc_i[1:0]};

  // History shifts in the resolved outcome at the LSB; bimodal builds carry no history.
  generate
    if (HIST_BITS == 0) begin : g_bimodal
      assign hist_idx = '0;
    end else begin : g_gshare
      logic [HIST_BITS-1:0] ghr_q;
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          ghr_q <= '0;
        end else if (update_en_i) begin
          ghr_q <= (ghr_q << 1) | HIST_BITS'(update_taken_i);
        end
      end
      assign hist_idx = INDEX_BITS'(ghr_q);
    end
  endgenerate

  // Lookup reads registered state only: a same-cycle update to the same entry is not forwarded.
  assign lookup_idx      = pc_i[INDEX_BITS+1:2] ^ hist_idx;
  assign lookup_cnt      = table_q[lookup_idx];
  assign predict_idx_o   = lookup_idx;
  assign predict_taken_o = is_branch_i & lookup_cnt[1];
  assign pc_predict_o    = (is_branch_i & ~lookup_cnt[1]) ? pc_plus_4_i : pc_next_i;

  // Update port is a valid-only pulse (update_en_i) with no ready: the table accepts one
  // resolved branch every cycle, and idx/taken/mispred are only meaningful while it is high.
  assign upd_cnt = table_q[update_idx_i];

  always_comb begin
    upd_cnt_next = upd_cnt;
    if (update_taken_i && upd_cnt != 2'b11) begin
      upd_cnt_next = upd_cnt + 2'b01;
    end else if (!update_taken_i && upd_cnt != 2'b00) begin
      upd_cnt_next = upd_cnt - 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= 2'b01;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (update_en_i) begin
      table_q[update_idx_i] <= upd_cnt_next;
      branch_cnt_q          <= branch_cnt_q + CNT_WIDTH'(1);
      if (update_mispred_i) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table: a bimodal 32-bit-stat instance and a
// 4-bit-history gshare instance with 4-bit stat counters to exercise wrap-around.
module tb_branch_history_table;

  logic        clk;
  logic        rst_nb, rst_ng;
  logic [31:0] pc, pc_next, pc_plus_4;
  logic        is_branch;
  logic        upd_en_b, upd_en_g;
  logic [5:0]  upd_idx;
  logic        upd_taken, upd_mis;

  logic        taken_b, taken_g;
  logic [31:0] pred_b, pred_g;
  logic [5:0]  idx_b, idx_g;
  logic [31:0] bcnt_b, mcnt_b;
  logic [3:0]  bcnt_g, mcnt_g;

  int n_checks = 0;
  int n_fail   = 0;

  branch_history_table #(.INDEX_BITS(6), .HIST_BITS(0), .CNT_WIDTH(32)) dut_b (
    .clk_i(clk), .rst_ni(rst_nb), .pc_i(pc), .is_branch_i(is_branch),
    .pc_next_i(pc_next), .pc_plus_4_i(pc_plus_4),
    .predict_taken_o(taken_b), .pc_predict_o(pred_b), .predict_idx_o(idx_b),
    .update_en_i(upd_en_b), .update_idx_i(upd_idx), .update_taken_i(upd_taken),
    .update_mispred_i(upd_mis), .branch_cnt_o(bcnt_b), .mispred_cnt_o(mcnt_b)
  );

  branch_history_table #(.INDEX_BITS(6), .HIST_BITS(4), .CNT_WIDTH(4)) dut_g (
    .clk_i(clk), .rst_ni(rst_ng), .pc_i(pc), .is_branch_i(is_branch),
    .pc_next_i(pc_next), .pc_plus_4_i(pc_plus_4),
    .predict_taken_o(taken_g), .pc_predict_o(pred_g), .predict_idx_o(idx_g),
    .update_en_i(upd_en_g), .update_idx_i(upd_idx), .update_taken_i(upd_taken),
    .update_mispred_i(upd_mis), .branch_cnt_o(bcnt_g), .mispred_cnt_o(mcnt_g)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [31:0] p, input logic br, input logic [31:0] nxt,
                        input logic [31:0] p4);
    pc = p; is_branch = br; pc_next = nxt; pc_plus_4 = p4;
    #1;
  endtask

  task automatic upd_b(input logic [5:0] idx, input logic tk, input logic mis);
    @(negedge clk);
    upd_en_b = 1'b1; upd_idx = idx; upd_taken = tk; upd_mis = mis;
    @(negedge clk);
    upd_en_b = 1'b0; upd_mis = 1'b0;
  endtask

  task automatic upd_g(input logic [5:0] idx, input logic tk, input logic mis);
    @(negedge clk);
    upd_en_g = 1'b1; upd_idx = idx; upd_taken = tk; upd_mis = mis;
    @(negedge clk);
    upd_en_g = 1'b0; upd_mis = 1'b0;
  endtask

  initial begin
    rst_nb = 1'b0; rst_ng = 1'b0;
    pc = '0; pc_next = '0; pc_plus_4 = '0; is_branch = 1'b0;
    upd_en_b = 1'b0; upd_en_g = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_mis = 1'b0;
    repeat (2) @(negedge clk);
    rst_nb = 1'b1; rst_ng = 1'b1;

    // Reset state and first lookup
    lookup(32'h100, 1'b1, 32'h140, 32'h104);
    chk("rst_taken_b", 32'(taken_b), 32'd0);
    chk("rst_pred_b", pred_b, 32'h104);
    chk("rst_idx_b", 32'(idx_b), 32'h00);
    chk("rst_idx_g", 32'(idx_g), 32'h00);
    chk("rst_pred_g", pred_g, 32'h104);
    chk("rst_bcnt_b", bcnt_b, 32'd0);
    chk("rst_mcnt_b", mcnt_b, 32'd0);

    // Entry 0 training: 01 -> 11 (saturate high) -> 00 (saturate low) -> 10
    upd_b(6'd0, 1'b1, 1'b1);
    upd_b(6'd0, 1'b1, 1'b0);
    lookup(32'h100, 1'b1, 32'h140, 32'h104);
    chk("t2_taken", 32'(taken_b), 32'd1);
    chk("t2_pred", pred_b, 32'h140);
    upd_b(6'd0, 1'b1, 1'b0);
    upd_b(6'd0, 1'b0, 1'b1);
    lookup(32'h100, 1'b1, 32'h140, 32'h104);
    chk("sat_hi_taken", 32'(taken_b), 32'd1);
    upd_b(6'd0, 1'b0, 1'b0);
    upd_b(6'd0, 1'b0, 1'b0);
    upd_b(6'd0, 1'b0, 1'b0);
    lookup(32'h100, 1'b1, 32'h140, 32'h104);
    chk("sat_lo_taken", 32'(taken_b), 32'd0);
    chk("sat_lo_pred", pred_b, 32'h104);
    upd_b(6'd0, 1'b1, 1'b0);
    lookup(32'h100, 1'b1, 32'h140, 32'h104);
    chk("from00_taken", 32'(taken_b), 32'd0);
    upd_b(6'd0, 1'b1, 1'b0);
    lookup(32'h100, 1'b1, 32'h140, 32'h104);
    chk("to10_taken", 32'(taken_b), 32'd1);

    // Non-branch jump over a taken entry passes pc_next through
    lookup(32'h100, 1'b0, 32'h0040_0000, 32'h104);
    chk("jump_taken", 32'(taken_b), 32'd0);
    chk("jump_pred", pred_b, 32'h0040_0000);

    // Same-cycle lookup and update at idx 5: pre-update value seen, new value next cycle
    @(negedge clk);
    upd_en_b = 1'b1; upd_idx = 6'd5; upd_taken = 1'b1; upd_mis = 1'b0;
    lookup(32'h14, 1'b1, 32'h80, 32'h18);
    chk("fwd_same_taken", 32'(taken_b), 32'd0);
    chk("fwd_same_pred", pred_b, 32'h18);
    @(negedge clk);
    upd_en_b = 1'b0;
    #1;
    chk("fwd_next_taken", 32'(taken_b), 32'd1);
    chk("fwd_next_pred", pred_b, 32'h80);

    // Mispred flag ignored without update_en
    @(negedge clk);
    upd_mis = 1'b1;
    @(negedge clk);
    upd_mis = 1'b0;
    #1;
    chk("stat_bcnt_b", bcnt_b, 32'd10);
    chk("stat_mcnt_b", mcnt_b, 32'd2);
    chk("gshare_idle_bcnt", 32'(bcnt_g), 32'd0);

    // Gshare history: T -> ghr 0001, T x3 -> 1111, N -> 1110
    upd_g(6'h20, 1'b1, 1'b0);
    lookup(32'h100, 1'b1, 32'h140, 32'h104);
    chk("ghr1_idx", 32'(idx_g), 32'h01);
    upd_g(6'h20, 1'b1, 1'b0);
    upd_g(6'h20, 1'b1, 1'b0);
    upd_g(6'h20, 1'b1, 1'b0);
    lookup(32'h100, 1'b1, 32'h140, 32'h104);
    chk("ghr4_idx", 32'(idx_g), 32'h0F);
    chk("ghr4_taken", 32'(taken_g), 32'd0);
    upd_g(6'h20, 1'b0, 1'b0);
    lookup(32'h100, 1'b1, 32'h140, 32'h104);
    chk("ghr_shift_idx", 32'(idx_g), 32'h0E);
    lookup(32'hB8, 1'b1, 32'h200, 32'hBC);
    chk("gs_hit_idx", 32'(idx_g), 32'h20);
    chk("gs_hit_taken", 32'(taken_g), 32'd1);
    chk("gs_hit_pred", pred_g, 32'h200);
    chk("gs_bcnt", 32'(bcnt_g), 32'd5);

    // Reset dominates a same-cycle update
    @(negedge clk);
    rst_ng = 1'b0; upd_en_g = 1'b1; upd_idx = 6'h20; upd_taken = 1'b1; upd_mis = 1'b1;
    @(negedge clk);
    rst_ng = 1'b1; upd_en_g = 1'b0; upd_mis = 1'b0;
    lookup(32'h100, 1'b1, 32'h140, 32'h104);
    chk("rstupd_idx", 32'(idx_g), 32'h00);
    chk("rstupd_bcnt", 32'(bcnt_g), 32'd0);
    chk("rstupd_mcnt", 32'(mcnt_g), 32'd0);
    lookup(32'h80, 1'b1, 32'h300, 32'h84);
    chk("rstupd_taken", 32'(taken_g), 32'd0);
    chk("rstupd_pred", pred_g, 32'h84);

    // 4-bit stat counters wrap after 16 updates
    for (int i = 0; i < 15; i++) upd_g(6'(i), 1'b0, 1'b1);
    #1;
    chk("wrap_pre_bcnt", 32'(bcnt_g), 32'd15);
    chk("wrap_pre_mcnt", 32'(mcnt_g), 32'd15);
    upd_g(6'd3, 1'b0, 1'b1);
    #1;
    chk("wrap_bcnt", 32'(bcnt_g), 32'd0);
    chk("wrap_mcnt", 32'(mcnt_g), 32'd0);

    // Fresh bimodal stats: 10 updates, mispredicts at i = 2, 5, 7
    @(negedge clk);
    rst_nb = 1'b0;
    @(negedge clk);
    rst_nb = 1'b1;
    #1;
    chk("stat_rst_bcnt", bcnt_b, 32'd0);
    for (int i = 0; i < 10; i++) upd_b(6'(i + 8), 1'b1, (i == 2 || i == 5 || i == 7));
    #1;
    chk("stat10_bcnt", bcnt_b, 32'd10);
    chk("stat10_mcnt", mcnt_b, 32'd3);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
